// File: rtl/sub_seq_pkg.sv
// Shared types and the nibble subtract for the serial subtract sequencer.
// Comparison flags are built only when SUB_SEQ_CTRL_CMP_EN is defined.
package sub_seq_pkg;
  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  function automatic logic [NIB_W:0] nib_sub(
    input logic [NIB_W-1:0] x,
    input logic [NIB_W-1:0] y,
    input logic             bi
  );
    return {1'b0, x} - {1'b0, y} - {{NIB_W{1'b0}}, bi};
  endfunction
endpackage

// File: rtl/sub4_slice.sv
// Combinational 4-bit borrow-ripple subtractor: {bo, d} = x - y - bi.
// Slice of the sub_seq_ctrl datapath.
module sub4_slice
  import sub_seq_pkg::*;
(
  input  logic [NIB_W-1:0] x,
  input  logic [NIB_W-1:0] y,
  input  logic             bi,
  output logic [NIB_W-1:0] d,
  output logic             bo
);
  assign {bo, d} = nib_sub(x, y, bi);
endmodule

// File: rtl/sub_seq_ctrl.sv
// Serial wide subtractor/comparator, one nibble per cycle, LSB first.
// Define SUB_SEQ_CTRL_CMP_EN to build the lt/eq/gt flags.
module sub_seq_ctrl
  import sub_seq_pkg::*;
#(
  parameter int NIB = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [NIB_W*NIB-1:0] a,
  input  logic [NIB_W*NIB-1:0] b,
  input  logic                 bin,
  output logic                 busy,
  output logic                 done,
  output logic [NIB_W*NIB-1:0] q,
  output logic                 bout,
  output logic                 lt,
  output logic                 eq,
  output logic                 gt
);
  localparam int W  = NIB_W * NIB;
  localparam int CW = $clog2(NIB);

  state_t state, state_nx;

  logic [CW-1:0]      cnt;
  logic [W-1:0]       a_sh;
  logic [W-1:0]       b_sh;
  logic [W-NIB_W-1:0] res_sh;
  logic               borrow_r;
  logic [NIB_W-1:0]   d;
  logic               bo;
  logic               last;
  logic [W-1:0]       q_nx;

  sub4_slice u_slice (
    .x  (a_sh[NIB_W-1:0]),
    .y  (b_sh[NIB_W-1:0]),
    .bi (borrow_r),
    .d  (d),
    .bo (bo)
  );

  assign last = (state == RUN) && (cnt == CW'(NIB - 1));
  assign q_nx = {d, res_sh};

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh     <= '0;
      b_sh     <= '0;
      res_sh   <= '0;
      borrow_r <= 1'b0;
      cnt      <= '0;
      q        <= '0;
      bout     <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        a_sh     <= a;
        b_sh     <= b;
        borrow_r <= bin;
        cnt      <= '0;
      end else if (state == RUN) begin
        a_sh     <= a_sh >> NIB_W;
        b_sh     <= b_sh >> NIB_W;
        res_sh   <= q_nx[W-1:NIB_W];
        borrow_r <= bo;
        cnt      <= last ? '0 : cnt + 1'b1;
      end
      if (last) begin
        q    <= q_nx;
        bout <= bo;
      end
    end
  end

`ifdef SUB_SEQ_CTRL_CMP_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lt <= 1'b0;
      eq <= 1'b0;
      gt <= 1'b0;
    end else if (last) begin
      lt <= bo;
      eq <= !bo && (q_nx == '0);
      gt <= !bo && (q_nx != '0);
    end
  end
`else
  assign lt = 1'b0;
  assign eq = 1'b0;
  assign gt = 1'b0;
`endif
endmodule

// File: tb/tb_sub_seq_ctrl.sv
// Directed and streaming checks for sub_seq_ctrl with NIB=4.
// Flag expectations follow SUB_SEQ_CTRL_CMP_EN.
module tb_sub_seq_ctrl;
  localparam int NIB = 4;
  localparam int W   = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         bin = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] q;
  logic         busy, done, bout, lt, eq, gt;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sub_seq_ctrl #(.NIB(NIB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .q     (q),
    .bout  (bout),
    .lt    (lt),
    .eq    (eq),
    .gt    (gt)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_res(input string tag, input logic [W-1:0] ta,
                         input logic [W-1:0] tb, input logic tbi);
    logic [W:0] r;
    logic [2:0] fl;
    r = {1'b0, ta} - {1'b0, tb} - (W+1)'(tbi);
`ifdef SUB_SEQ_CTRL_CMP_EN
    fl = {r[W], !r[W] && (r[W-1:0] == '0), !r[W] && (r[W-1:0] != '0)};
`else
    fl = 3'b000;
`endif
    chk({tag, ".q"}, 32'(q), 32'(r[W-1:0]));
    chk({tag, ".bout"}, 32'(bout), 32'(r[W]));
    chk({tag, ".flags"}, 32'({lt, eq, gt}), 32'(fl));
  endtask

  task automatic wait_done(input string tag, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!done && lat < 20);
    chk({tag, ".done_seen"}, 32'(done), 32'd1);
  endtask

  task automatic op(input string tag, input logic [W-1:0] ta,
                    input logic [W-1:0] tb, input logic tbi,
                    output int lat);
    @(negedge clk);
    a = ta; b = tb; bin = tbi; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = ~ta; b = ta; bin = ~tbi;
    wait_done(tag, lat);
  endtask

  int lat;
  int nd;
  logic [W-1:0] ra, rb;
  logic rbi;

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.busy", 32'(busy), 0);
    chk("rst.done", 32'(done), 0);
    chk("rst.q", 32'(q), 0);
    chk("rst.bout", 32'(bout), 0);
    chk("rst.flags", 32'({lt, eq, gt}), 0);
    rst_n = 1'b1;

    op("t1", 16'h1234, 16'h0234, 1'b0, lat);
    chk("t1.lat", 32'(lat), 32'd5);
    chk_res("t1", 16'h1234, 16'h0234, 1'b0);
    chk("t1.q_abs", 32'(q), 32'h1000);
    chk("t1.busy", 32'(busy), 1);
    @(negedge clk);
    chk("t1.pulse", 32'(done), 0);
    chk("t1.idle", 32'(busy), 0);

    op("t2", 16'h0000, 16'h0001, 1'b0, lat);
    chk_res("t2", 16'h0000, 16'h0001, 1'b0);
    chk("t2.q_abs", 32'(q), 32'hFFFF);
    chk("t2.bout_abs", 32'(bout), 1);

    op("t3", 16'hBEEF, 16'hBEEF, 1'b0, lat);
    chk_res("t3", 16'hBEEF, 16'hBEEF, 1'b0);
    op("t4", 16'h0005, 16'h0004, 1'b1, lat);
    chk_res("t4", 16'h0005, 16'h0004, 1'b1);
    chk("t4.q_abs", 32'(q), 0);

    // second start arrives mid-RUN with different operands
    @(negedge clk);
    a = 16'h8000; b = 16'h0001; bin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    a = 16'hFFFF; b = 16'h0000; bin = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) begin
        nd++;
        chk_res("ign", 16'h8000, 16'h0001, 1'b0);
      end
    end
    chk("ign.ndone", 32'(nd), 1);

    // reset lands on the second RUN cycle
    @(negedge clk);
    a = 16'h4321; b = 16'h1111; bin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mr.busy", 32'(busy), 0);
    chk("mr.done", 32'(done), 0);
    chk("mr.q", 32'(q), 0);
    chk("mr.bout", 32'(bout), 0);
    chk("mr.flags", 32'({lt, eq, gt}), 0);
    rst_n = 1'b1;
    nd = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("mr.nodone", 32'(nd), 0);
    op("mr2", 16'h4321, 16'h1111, 1'b0, lat);
    chk("mr2.lat", 32'(lat), 32'd5);
    chk_res("mr2", 16'h4321, 16'h1111, 1'b0);

    // streaming with start held high
    @(negedge clk);
    ra = W'($urandom); rb = W'($urandom); rbi = 1'($urandom);
    a = ra; b = rb; bin = rbi; start = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      wait_done("rnd", lat);
      chk("rnd.space", 32'(lat), (i == 0) ? 32'd5 : 32'd6);
      chk_res("rnd", ra, rb, rbi);
      ra = W'($urandom); rb = W'($urandom); rbi = 1'($urandom);
      if (i % 7 == 0) rb = ra;
      a = ra; b = rb; bin = rbi;
    end
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("end.idle", 32'(busy), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
